// File: rtl/hazard_sequencer.sv
// hazard_sequencer
// Pipeline sequencing controller for the 5-stage MIPS core. Keeps a shadow
// copy of the ID/EX, EX/MEM and MEM/WB control state and uses it to drive the
// PC / pipeline-register enables, per-stage flushes and ALU forwarding selects.
// Saturating stall and flush counters are kept for performance debug.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   mem_ready             0 freezes the whole pipeline
//   id_valid, id_opcode,
//   id_rs, id_rt, id_rd   instruction currently in ID
//   branch_taken          branch in MEM resolved taken
//   pc_write, if_id_write,
//   pipe_enable           PC / IF/ID / downstream pipeline load enables
//   if_id_flush, id_ex_flush,
//   ex_mem_flush          per-stage bubble insertion
//   forward_a, forward_b  ALU operand selects: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_count, flush_count  saturating performance counters
//
// Cycle action (combinational, highest priority first):
//   mode        | meaning
//   MODE_RESET  | reset high: enables off, all flushes on
//   MODE_FREEZE | mem_ready low: everything held, nothing flushed
//   MODE_BRANCH | taken branch in MEM: flush IF/ID, ID/EX, EX/MEM
//   MODE_JUMP   | J in ID: flush IF/ID only
//   MODE_STALL  | load-use: hold PC and IF/ID, bubble into ID/EX
//   MODE_RUN    | normal advance
module hazard_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mem_ready,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             pipe_enable,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_read;
        logic [4:0] dest;
        logic [4:0] rs;
        logic [4:0] rt;
    } entry_t;

    typedef enum logic [2:0] {
        MODE_RESET,
        MODE_FREEZE,
        MODE_BRANCH,
        MODE_JUMP,
        MODE_STALL,
        MODE_RUN
    } mode_t;

    entry_t id_entry;
    entry_t id_ex_q, ex_mem_q, mem_wb_q;
    entry_t id_ex_d, ex_mem_d, mem_wb_d;
    logic   id_uses_rt;
    logic   load_use;
    logic   stall_inc;
    logic   flush_inc;
    mode_t  mode;

    function automatic logic is_hazard(input entry_t e);
        return e.valid && e.reg_write && (e.dest != 5'd0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input entry_t    ex_mem,
                                           input entry_t    mem_wb);
        if (is_hazard(ex_mem) && ex_mem.dest == src)
            return 2'b10;
        else if (is_hazard(mem_wb) && mem_wb.dest == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Decode of the ID instruction into a shadow entry.
    always_comb begin
        id_entry   = '0;
        id_uses_rt = 1'b0;
        if (id_valid) begin
            id_entry.valid = 1'b1;
            id_entry.rs    = id_rs;
            id_entry.rt    = id_rt;
            id_entry.dest  = (id_opcode == OP_RTYPE) ? id_rd : id_rt;
            case (id_opcode)
                OP_RTYPE: begin
                    id_entry.reg_write = 1'b1;
                    id_uses_rt         = 1'b1;
                end
                OP_LW: begin
                    id_entry.reg_write = 1'b1;
                    id_entry.mem_read  = 1'b1;
                end
                OP_ADDI, OP_LUI, OP_ORI: id_entry.reg_write = 1'b1;
                OP_SW, OP_BEQ, OP_BNE:   id_uses_rt = 1'b1;
                default: ;
            endcase
        end
    end

    // A bubble in ID reads nothing, so it never triggers a load-use stall.
    assign load_use = id_valid && id_ex_q.valid && id_ex_q.mem_read &&
                      (id_ex_q.dest != 5'd0) &&
                      ((id_ex_q.dest == id_rs) ||
                       (id_uses_rt && (id_ex_q.dest == id_rt)));

    always_comb begin
        if (reset)
            mode = MODE_RESET;
        else if (!mem_ready)
            mode = MODE_FREEZE;
        else if (branch_taken)
            mode = MODE_BRANCH;
        else if (id_valid && id_opcode == OP_J)
            mode = MODE_JUMP;
        else if (load_use)
            mode = MODE_STALL;
        else
            mode = MODE_RUN;
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        pipe_enable  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        id_ex_d      = id_entry;
        ex_mem_d     = id_ex_q;
        mem_wb_d     = ex_mem_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        case (mode)
            MODE_RESET: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                pipe_enable  = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                id_ex_d      = '0;
                ex_mem_d     = '0;
                mem_wb_d     = '0;
            end
            MODE_FREEZE: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_enable = 1'b0;
                id_ex_d     = id_ex_q;
                ex_mem_d    = ex_mem_q;
                mem_wb_d    = mem_wb_q;
            end
            MODE_BRANCH: begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                id_ex_d      = '0;
                ex_mem_d     = '0;
                flush_inc    = 1'b1;
            end
            MODE_JUMP: begin
                if_id_flush = 1'b1;
                flush_inc   = 1'b1;
            end
            MODE_STALL: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                id_ex_d     = '0;
                stall_inc   = 1'b1;
            end
            default: ;
        endcase
    end

    assign forward_a = (reset || !id_ex_q.valid) ? 2'b00
                                                 : fwd_sel(id_ex_q.rs, ex_mem_q, mem_wb_q);
    assign forward_b = (reset || !id_ex_q.valid) ? 2'b00
                                                 : fwd_sel(id_ex_q.rt, ex_mem_q, mem_wb_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            id_ex_q     <= '0;
            ex_mem_q    <= '0;
            mem_wb_q    <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
            if (stall_inc && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            if (flush_inc && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Testbench for hazard_sequencer: directed vector table, multi-cycle
// freeze / reset / saturation sequences, then random stimulus against a
// stage-list reference model.
module tb_hazard_sequencer;

    localparam int W = 4;   // narrow counters so saturation is reachable

    localparam logic [5:0] R   = 6'h00;
    localparam logic [5:0] J   = 6'h02;
    localparam logic [5:0] BEQ = 6'h04;
    localparam logic [5:0] BNE = 6'h05;
    localparam logic [5:0] ADI = 6'h08;
    localparam logic [5:0] ORI = 6'h0D;
    localparam logic [5:0] LUI = 6'h0F;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] SW  = 6'h2B;

    logic         clock = 1'b0;
    logic         reset;
    logic         mem_ready;
    logic         id_valid;
    logic [5:0]   id_opcode;
    logic [4:0]   id_rs, id_rt, id_rd;
    logic         branch_taken;
    logic         pc_write, if_id_write, pipe_enable;
    logic         if_id_flush, id_ex_flush, ex_mem_flush;
    logic [1:0]   forward_a, forward_b;
    logic [W-1:0] stall_count, flush_count;

    int total = 0;
    int bad   = 0;

    hazard_sequencer #(.CNT_W(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .mem_ready    (mem_ready),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .pipe_enable  (pipe_enable),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .forward_a    (forward_a),
        .forward_b    (forward_b),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] dut_ctl();
        return {pc_write, if_id_write, pipe_enable,
                if_id_flush, id_ex_flush, ex_mem_flush, forward_a, forward_b};
    endfunction

    task automatic drive(input logic rst, input logic mr, input logic idv,
                         input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic br);
        reset = rst; mem_ready = mr; id_valid = idv; id_opcode = op;
        id_rs = rs; id_rt = rt; id_rd = rd; branch_taken = br;
    endtask

    // Inputs are already driven; settle, compare, then take one clock.
    task automatic step_check(input string name, input logic [9:0] exp_ctl,
                              input int sc, input int fc);
        #2;
        check({name, " ctl"}, 32'(dut_ctl()), 32'(exp_ctl));
        check({name, " stall_count"}, 32'(stall_count), sc);
        check({name, " flush_count"}, 32'(flush_count), fc);
        @(posedge clock); #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst, mr, idv;
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        logic       br;
        logic [5:0] ctl;    // {pc, if_id, pipe, f_if_id, f_id_ex, f_ex_mem}
        logic [1:0] fa, fb;
        int         sc, fc;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic mr, input logic idv,
                                input logic [5:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic br, input logic [5:0] ctl,
                                input logic [1:0] fa, input logic [1:0] fb,
                                input int sc, input int fc);
        vec_t v;
        v.rst = rst; v.mr = mr; v.idv = idv; v.op = op; v.rs = rs; v.rt = rt;
        v.rd = rd; v.br = br; v.ctl = ctl; v.fa = fa; v.fb = fb; v.sc = sc; v.fc = fc;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Stage list: index 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB.
    typedef struct {
        bit       v, rw, mr;
        bit [4:0] d, rs, rt;
    } ment_t;

    ment_t stg [3];
    int    m_stall, m_flush;

    function automatic bit writes_reg(input logic [5:0] op);
        return op inside {R, LW, ADI, LUI, ORI};
    endfunction

    function automatic bit reads_rt(input logic [5:0] op);
        return op inside {R, BEQ, BNE, SW};
    endfunction

    function automatic ment_t id_ment();
        ment_t e;
        e = '{default: 0};
        if (id_valid) begin
            e.v  = 1; e.rw = writes_reg(id_opcode); e.mr = (id_opcode == LW);
            e.d  = (id_opcode == R) ? id_rd : id_rt;
            e.rs = id_rs; e.rt = id_rt;
        end
        return e;
    endfunction

    function automatic bit m_load_use();
        if (!id_valid || !stg[0].v || !stg[0].mr || stg[0].d == 0) return 0;
        return (stg[0].d == id_rs) || (reads_rt(id_opcode) && stg[0].d == id_rt);
    endfunction

    function automatic logic [1:0] m_fwd(input bit [4:0] src);
        if (reset || !stg[0].v) return 2'b00;
        for (int s = 1; s <= 2; s++)
            if (stg[s].v && stg[s].rw && stg[s].d != 0 && stg[s].d == src)
                return (s == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    // 0 reset, 1 freeze, 2 branch, 3 jump, 4 stall, 5 run
    function automatic int m_action();
        if (reset) return 0;
        if (!mem_ready) return 1;
        if (branch_taken) return 2;
        if (id_valid && id_opcode == J) return 3;
        if (m_load_use()) return 4;
        return 5;
    endfunction

    function automatic logic [9:0] m_ctl();
        logic [5:0] c;
        case (m_action())
            0: c = 6'b000111;
            1: c = 6'b000000;
            2: c = 6'b111111;
            3: c = 6'b111100;
            4: c = 6'b001010;
            default: c = 6'b111000;
        endcase
        return {c, m_fwd(stg[0].rs), m_fwd(stg[0].rt)};
    endfunction

    task automatic m_clock();
        ment_t bub, nid;
        int    sat;
        bub = '{default: 0};
        nid = id_ment();
        sat = (1 << W) - 1;
        case (m_action())
            0: begin stg[0] = bub; stg[1] = bub; stg[2] = bub; m_stall = 0; m_flush = 0; end
            1: ;
            2: begin
                stg[2] = stg[1]; stg[1] = bub; stg[0] = bub;
                if (m_flush < sat) m_flush++;
            end
            3: begin
                stg[2] = stg[1]; stg[1] = stg[0]; stg[0] = nid;
                if (m_flush < sat) m_flush++;
            end
            4: begin
                stg[2] = stg[1]; stg[1] = stg[0]; stg[0] = bub;
                if (m_stall < sat) m_stall++;
            end
            default: begin stg[2] = stg[1]; stg[1] = stg[0]; stg[0] = nid; end
        endcase
    endtask

    logic [5:0] ops [9];
    vec_t       tv  [17];

    initial begin
        ops = '{R, LW, SW, BEQ, BNE, ADI, LUI, ORI, J};

        // Reset row then ADD stream, forwarding, load-use, $0 load, branch, jump.
        tv[0]  = mk(1'b1,1'b1,1'b0,R ,5'd0,5'd0,5'd0,1'b0,6'b000111,2'b00,2'b00,0,0);
        tv[1]  = mk(1'b0,1'b1,1'b1,R ,5'd1,5'd2,5'd3,1'b0,6'b111000,2'b00,2'b00,0,0);
        tv[2]  = mk(1'b0,1'b1,1'b1,R ,5'd3,5'd5,5'd4,1'b0,6'b111000,2'b00,2'b00,0,0);
        tv[3]  = mk(1'b0,1'b1,1'b1,R ,5'd3,5'd7,5'd6,1'b0,6'b111000,2'b10,2'b00,0,0);
        tv[4]  = mk(1'b0,1'b1,1'b0,R ,5'd0,5'd0,5'd0,1'b0,6'b111000,2'b01,2'b00,0,0);
        tv[5]  = mk(1'b0,1'b1,1'b1,LW,5'd1,5'd2,5'd0,1'b0,6'b111000,2'b00,2'b00,0,0);
        tv[6]  = mk(1'b0,1'b1,1'b1,R ,5'd2,5'd2,5'd4,1'b0,6'b001010,2'b00,2'b00,0,0);
        tv[7]  = mk(1'b0,1'b1,1'b1,R ,5'd2,5'd2,5'd4,1'b0,6'b111000,2'b00,2'b00,1,0);
        tv[8]  = mk(1'b0,1'b1,1'b0,R ,5'd0,5'd0,5'd0,1'b0,6'b111000,2'b01,2'b01,1,0);
        tv[9]  = mk(1'b0,1'b1,1'b1,LW,5'd1,5'd0,5'd0,1'b0,6'b111000,2'b00,2'b00,1,0);
        tv[10] = mk(1'b0,1'b1,1'b1,R ,5'd0,5'd0,5'd4,1'b0,6'b111000,2'b00,2'b00,1,0);
        tv[11] = mk(1'b0,1'b1,1'b0,R ,5'd0,5'd0,5'd0,1'b0,6'b111000,2'b00,2'b00,1,0);
        tv[12] = mk(1'b0,1'b1,1'b1,R ,5'd4,5'd4,5'd5,1'b1,6'b111111,2'b00,2'b00,1,0);
        tv[13] = mk(1'b0,1'b1,1'b1,R ,5'd4,5'd4,5'd5,1'b0,6'b111000,2'b00,2'b00,1,1);
        tv[14] = mk(1'b0,1'b1,1'b0,R ,5'd0,5'd0,5'd0,1'b0,6'b111000,2'b00,2'b00,1,1);
        tv[15] = mk(1'b0,1'b1,1'b1,J ,5'd0,5'd0,5'd0,1'b0,6'b111100,2'b00,2'b00,1,1);
        tv[16] = mk(1'b0,1'b1,1'b0,R ,5'd0,5'd0,5'd0,1'b0,6'b111000,2'b00,2'b00,1,2);

        drive(1'b1, 1'b1, 1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0);
        @(posedge clock); #1;

        for (int i = 0; i < 17; i++) begin
            drive(tv[i].rst, tv[i].mr, tv[i].idv, tv[i].op,
                  tv[i].rs, tv[i].rt, tv[i].rd, tv[i].br);
            step_check($sformatf("vec%0d", i), {tv[i].ctl, tv[i].fa, tv[i].fb},
                       tv[i].sc, tv[i].fc);
        end

        // Freeze over a load-use hazard with a pending branch: branch wins after.
        drive(1'b0, 1'b1, 1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0);
        step_check("frz_lw", 10'b111000_00_00, 1, 2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, R, 5'd2, 5'd2, 5'd4, 1'b1);
            step_check($sformatf("frz%0d", i), 10'b000000_00_00, 1, 2);
        end
        drive(1'b0, 1'b1, 1'b1, R, 5'd2, 5'd2, 5'd4, 1'b1);
        step_check("frz_release", 10'b111111_00_00, 1, 2);
        drive(1'b0, 1'b1, 1'b1, R, 5'd2, 5'd2, 5'd4, 1'b0);
        step_check("frz_after", 10'b111000_00_00, 1, 3);

        // Reset landing on a load-use stall cycle clears everything.
        drive(1'b0, 1'b1, 1'b1, LW, 5'd1, 5'd2, 5'd0, 1'b0);
        step_check("rst_lw", 10'b111000_00_00, 1, 3);
        drive(1'b1, 1'b1, 1'b1, R, 5'd2, 5'd2, 5'd4, 1'b0);
        step_check("rst_mid_stall", 10'b000111_00_00, 1, 3);
        drive(1'b0, 1'b1, 1'b1, R, 5'd2, 5'd2, 5'd4, 1'b0);
        step_check("rst_after", 10'b111000_00_00, 0, 0);

        // Flush counter saturation.
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b0, R, 5'd0, 5'd0, 5'd0, 1'b1);
            step_check($sformatf("sat%0d", i), 10'b111111_00_00, 0,
                       (i < 15) ? i : 15);
        end
        drive(1'b0, 1'b1, 1'b0, R, 5'd0, 5'd0, 5'd0, 1'b0);
        #2;
        check("sat_final", 32'(flush_count), 15);
        @(posedge clock); #1;

        // Random stimulus against the stage-list model.
        stg[0] = '{default: 0}; stg[1] = '{default: 0}; stg[2] = '{default: 0};
        m_stall = 0; m_flush = 0;
        for (int i = 0; i < 1500; i++) begin
            drive((i == 0) || ($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 99) < 85),
                  ($urandom_range(0, 99) < 85),
                  ops[$urandom_range(0, 8)],
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  ($urandom_range(0, 99) < 8));
            #2;
            check($sformatf("rnd%0d ctl", i), 32'(dut_ctl()), 32'(m_ctl()));
            if (i > 0) begin
                check($sformatf("rnd%0d stall_count", i), 32'(stall_count), m_stall);
                check($sformatf("rnd%0d flush_count", i), 32'(flush_count), m_flush);
            end
            @(posedge clock);
            m_clock();
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
